// File: rtl/wb_src_arbiter_if.sv
// wb_src_arbiter_if: writeback arbiter bus between the result producers and the arbiter
// Ports: req/burst/dst_addr/hold from the producers; src_sel/reg_wr/wr_addr/ack/busy from the arbiter.
// Modports: master = producer side, slave = arbiter side.
interface wb_src_arbiter_if #(parameter int N_SRC = 11);
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] burst;
  logic [5*N_SRC-1:0] dst_addr;
  logic hold;
  logic [3:0] src_sel;
  logic reg_wr;
  logic [4:0] wr_addr;
  logic [N_SRC-1:0] ack;
  logic busy;
  modport master (output req, burst, dst_addr, hold, input src_sel, reg_wr, wr_addr, ack, busy);
  modport slave (input req, burst, dst_addr, hold, output src_sel, reg_wr, wr_addr, ack, busy);
endinterface

// File: rtl/wb_src_arbiter.sv
// wb_src_arbiter: round-robin register-file writeback arbiter with two-beat bursts
// Ports: clk, reset (async, active-low), bus (wb_src_arbiter_if.slave):
//   req/burst/dst_addr/hold in; src_sel/reg_wr/wr_addr/ack/busy out, all registered.
module wb_src_arbiter #(parameter int N_SRC = 11) (
  input logic clk,
  input logic reset,
  wb_src_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;
  state_t state_q, state_d;
  logic burst_q, burst_d;
  logic [3:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] src_sel_q, src_sel_d;
  logic reg_wr_q, reg_wr_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic [N_SRC-1:0] cand;
  logic [4:0] idx;
  logic [3:0] win;
  logic found;
  // The requester being acked this cycle is masked so it is not granted again while it drops req.
  always_comb begin
    cand = bus.req & ~ack_q;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = 5'(rr_ptr_q) + 5'(k);
      idx = (idx >= 5'(N_SRC)) ? idx - 5'(N_SRC) : idx;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = idx[3:0];
      end
    end
  end
  always_comb begin
    state_d = IDLE;
    burst_d = burst_q;
    rr_ptr_d = rr_ptr_q;
    src_sel_d = src_sel_q;
    wr_addr_d = wr_addr_q;
    ack_d = '0;
    // The first beat of a burst always proceeds to the second, regardless of hold or other requests.
    if (state_q == BEAT1 && burst_q) begin
      state_d = BEAT2;
      wr_addr_d = bus.dst_addr[5*src_sel_q +: 5];
      ack_d[src_sel_q] = 1'b1;
    end else if (!bus.hold && found) begin
      state_d = BEAT1;
      src_sel_d = win;
      burst_d = bus.burst[win];
      rr_ptr_d = (win == 4'(N_SRC-1)) ? 4'd0 : win + 4'd1;
      wr_addr_d = bus.dst_addr[5*win +: 5];
      ack_d[win] = !bus.burst[win];
    end
    // Writes to $zero are suppressed, but the grant still runs so the producer is released.
    reg_wr_d = (state_d != IDLE) && (wr_addr_d != 5'd0);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      burst_q <= 1'b0;
      rr_ptr_q <= '0;
      src_sel_q <= '0;
      reg_wr_q <= 1'b0;
      wr_addr_q <= '0;
      ack_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      rr_ptr_q <= rr_ptr_d;
      src_sel_q <= src_sel_d;
      reg_wr_q <= reg_wr_d;
      wr_addr_q <= wr_addr_d;
      ack_q <= ack_d;
    end
  end
  assign bus.src_sel = src_sel_q;
  assign bus.reg_wr = reg_wr_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.ack = ack_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_wb_src_arbiter.sv
// tb_wb_src_arbiter: randomized and directed self-checking bench for wb_src_arbiter against a behavioural model
module tb_wb_src_arbiter;
  localparam int N = 11;
  logic clk;
  logic reset;
  int n_tests = 0;
  int n_fail = 0;
  wb_src_arbiter_if #(.N_SRC(N)) bus ();
  wb_src_arbiter #(.N_SRC(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // Behavioural model: who owns the writeback port, what it shows, and where the next search starts.
  int m_sel, m_ptr;
  logic m_wr, m_busy, m_second_owed;
  logic [4:0] m_addr;
  logic [N-1:0] m_ack;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_sel = 0;
    m_ptr = 0;
    m_wr = 0;
    m_busy = 0;
    m_second_owed = 0;
    m_addr = 0;
    m_ack = '0;
  endtask
  task automatic model_edge();
    logic [N-1:0] cand;
    int w;
    if (m_second_owed) begin
      m_second_owed = 0;
      m_addr = bus.dst_addr[5*m_sel +: 5];
      m_ack = '0;
      m_ack[m_sel] = 1'b1;
      m_busy = 1;
    end else begin
      cand = bus.req & ~m_ack;
      w = -1;
      if (!bus.hold)
        for (int k = 0; k < N; k++)
          if (w < 0 && cand[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_ack = '0;
      if (w < 0) m_busy = 0;
      else begin
        m_sel = w;
        m_ptr = (w + 1) % N;
        m_addr = bus.dst_addr[5*w +: 5];
        m_busy = 1;
        m_second_owed = bus.burst[w];
        if (!bus.burst[w]) m_ack[w] = 1'b1;
      end
    end
    m_wr = m_busy && (m_addr != 5'd0);
  endtask
  task automatic compare_all();
    check("src_sel", 32'(bus.src_sel), 32'(m_sel));
    check("reg_wr", 32'(bus.reg_wr), 32'(m_wr));
    check("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
    check("ack", 32'(bus.ack), 32'(m_ack));
    check("busy", 32'(bus.busy), 32'(m_busy));
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask
  task automatic set_dst(input int i, input logic [4:0] v);
    bus.dst_addr[5*i +: 5] = v;
  endtask
  task automatic pulse_reset();
    reset = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1;
  endtask
  initial begin
    clk = 0;
    reset = 0;
    bus.req = '1;
    bus.burst = '0;
    bus.hold = 0;
    for (int i = 0; i < N; i++) set_dst(i, 5'(i + 1));
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1;
    step();
    check("first_grant_sel", 32'(bus.src_sel), 32'd0);
    step();
    check("second_grant_sel", 32'(bus.src_sel), 32'd1);
    pulse_reset();
    bus.req = 11'b00000100101;
    set_dst(0, 5);
    set_dst(2, 6);
    set_dst(5, 7);
    repeat (6) step();
    bus.req = '0;
    step();
    bus.req = 11'(1) << 3;
    bus.burst = 11'(1) << 3;
    set_dst(3, 9);
    step();
    check("burst_beat1_ack", 32'(bus.ack), 32'd0);
    bus.req = bus.req | 11'(1) << 1;
    set_dst(3, 10);
    step();
    check("burst_beat2_addr", 32'(bus.wr_addr), 32'd10);
    bus.req = 11'(1) << 1;
    bus.burst = '0;
    step();
    check("after_burst_sel", 32'(bus.src_sel), 32'd1);
    bus.req = 11'(1) << 10;
    set_dst(10, 0);
    step();
    check("zero_reg_wr", 32'(bus.reg_wr), 32'd0);
    bus.req = '0;
    step();
    bus.hold = 1;
    bus.req = 11'b10;
    step();
    step();
    check("hold_busy", 32'(bus.busy), 32'd0);
    bus.hold = 0;
    bus.req = 11'(1) << 4;
    bus.burst = 11'(1) << 4;
    step();
    bus.hold = 1;
    step();
    check("hold_beat2_reg_wr", 32'(bus.reg_wr), 32'd1);
    step();
    check("hold_after_beat2_busy", 32'(bus.busy), 32'd0);
    bus.hold = 0;
    bus.req = 11'(1) << 6;
    bus.burst = 11'(1) << 6;
    step();
    #2 reset = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1;
    step();
    check("restart_sel", 32'(bus.src_sel), 32'd6);
    check("restart_ack", 32'(bus.ack), 32'd0);
    step();
    bus.req = '0;
    bus.burst = '0;
    step();
    for (int t = 0; t < 3000; t++) begin
      bus.req = 11'($urandom) & 11'($urandom);
      bus.burst = 11'($urandom) & 11'($urandom);
      bus.hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) set_dst(i, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_src_arbiter.md
# wb_src_arbiter

Register-file writeback arbiter for the multicycle datapath. Up to 11 result producers (ALU, load unit, shifter, HI/LO, immediates, PC+4 link, etc.) request a write into the register file. The block grants one producer per cycle using round-robin priority. It drives the 4-bit select of the 11-input writeback-data multiplexer, the register-file write enable and the destination address, and returns a one-hot acknowledge. Two-beat bursts are supported for producers that must write on consecutive cycles.

## Interface
- `N_SRC`, 11, number of requesters; legal range 2..11, since select values 11..15 alias to input 10 in the data mux.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; 0 = reset.
- `req` input N_SRC: per-requester write request, level; held until acknowledged.
- `burst` input N_SRC: per-requester two-beat flag; sampled with `req` at grant.
- `dst_addr` input 5*N_SRC: destination register of requester i in bits [5i+4:5i].
- `hold` input 1: 1 blocks launch of new grants.
- `src_sel` output 4: data-mux select, equal to granted index.
- `reg_wr` output 1: register-file write enable.
- `wr_addr` output 5: register-file write address.
- `ack` output N_SRC: one-hot, 1-cycle pulse on the final beat of a grant.
- `busy` output 1: 1 while a grant (single beat or burst) is in progress.

## Operation
- FSM states:
  - IDLE: no grant.
  - BEAT1: single beat, or first beat of a burst.
  - BEAT2: second burst beat.
- **Candidate set.** `req & ~ack`. Masking the requester currently being acked prevents double grants while it drops `req`.
- **Round-robin selection.**
  - Search starts at `rr_ptr` and runs upward, wrapping from N_SRC-1 to 0. The first candidate found wins.
  - On each launch, `rr_ptr` becomes winner+1, wrapping at N_SRC.
- **Launch.** Occurs at a rising edge when `hold`=0, state ≠ BEAT1-with-burst, and the candidate set is nonzero.
  - Next state is BEAT1.
  - `src_sel` is loaded with the winner index.
  - The burst flag is latched.
- **BEAT1 outputs.**
  - `reg_wr`=1; `wr_addr`=registered `dst_addr` of the winner.
  - If not a burst: `ack[winner]`=1.
  - If a burst: `ack`=0. The next edge enters BEAT2 unconditionally; `hold` is ignored.
- **BEAT2 outputs.**
  - `src_sel` is unchanged.
  - `wr_addr` is resampled from the winner's `dst_addr` at the BEAT1→BEAT2 edge.
  - `reg_wr`=1 and `ack[winner]`=1.
- **Back-to-back grants.** From BEAT1 (non-burst) or BEAT2, a new launch may occur at the same edge. There is no idle bubble.
- **Return to IDLE.** With no candidates or `hold`=1, the state returns to IDLE and `reg_wr`, `ack` and `busy` go to 0.
- **$zero.** When `wr_addr`=0, `reg_wr` is forced to 0. `ack` and `busy` still behave normally, so the producer is released.
- **Indices.** `src_sel` never exceeds N_SRC-1. In IDLE it holds its last value; the reset value is 0.

## Timing
- Reset values, applied asynchronously: state IDLE, `rr_ptr`=0, `src_sel`=0, `reg_wr`=0, `wr_addr`=0, `ack`=0, `busy`=0.
- All outputs are registered. A request sampled at edge k yields `reg_wr`/`ack` during cycle k..k+1, giving 1-cycle latency.
- Burst: writes occur in cycles k..k+1 and k+1..k+2; `ack` is asserted in the second cycle only.
- Requester rule: on seeing `ack[i]`=1, deassert `req[i]` by the next edge, or keep it high to request again. After the ack cycle, a held `req[i]` is a new request.
- `busy` = (state ≠ IDLE).
- `hold` asserted during BEAT2 has no effect on that beat. It only blocks the following launch.
- Reset deasserting mid-burst leaves the state in IDLE, with no ack owed. Requesters retry by holding `req`.
- Simultaneous requests: exactly one grant per launch. A requester waits at most N_SRC-1 grants.

## Test plan
- **Reset.** Apply reset with `req`=all-ones → all outputs 0. After release, the first grant is index 0 with `src_sel`=0 and `rr_ptr`=1.
- **Round-robin.** `req`=0b00000100101 held with dst 5, 6, 7 → grants 0, 2, 5, 0, … on consecutive cycles. Each `ack` is one-hot, `reg_wr`=1, and `wr_addr` tracks the destination.
- **Burst.** `req[3]`=1, `burst[3]`=1, dst 9 then 10, with `req[1]` also pending → `reg_wr` for two cycles with `src_sel`=3 and `wr_addr` 9 then 10. `ack[3]` only on the second beat. Grant 1 follows on the next cycle.
- **$zero.** `req[10]` with dst 0 → `src_sel`=10, `reg_wr`=0, `ack[10]`=1, `busy`=1 for one cycle.
- **Hold.** `hold`=1 with `req`=0b10 → no grant and `busy`=0. Asserting `hold` during BEAT2 of a burst → the beat completes, then IDLE.
- **Async reset mid-burst.** `reset`=0 during BEAT1 → outputs clear immediately without a clock edge. After release, the burst restarts from BEAT1 if `req` is still high.
